// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: control-bit positions for the EX/MEM and MEM/WB
// control fields, and the memory-stage state encoding.
package mips_pkg;

    localparam int unsigned BRANCH   = 2;
    localparam int unsigned MEMREAD  = 1;
    localparam int unsigned MEMWRITE = 0;
    localparam int unsigned REGWRITE = 1;
    localparam int unsigned MEMTOREG = 0;

    typedef enum logic {
        StIdle = 1'b0,
        StReq  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Memory-stage signal bundle: EX/MEM inputs, branch resolution, data-memory handshake
// and MEM/WB outputs. master = the controller, slave = the surrounding pipeline/memory.
interface mem_stage_ctrl_if;

    logic        in_valid;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic [31:0] add_result;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2;
    logic [4:0]  dest_reg;

    logic        pc_src;
    logic [31:0] branch_target;
    logic        mem_stall;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    logic        wb_valid;
    logic [1:0]  wb_ctlout;
    logic [31:0] wb_rdata;
    logic [31:0] wb_alu;
    logic [4:0]  wb_dest;
    logic        mem_misalign;

    modport master (
        input  in_valid, wb_ctl, m_ctl, add_result, zero, alu_result, rdata2, dest_reg,
        input  dmem_ack, dmem_rdata,
        output pc_src, branch_target, mem_stall,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output wb_valid, wb_ctlout, wb_rdata, wb_alu, wb_dest, mem_misalign
    );

    modport slave (
        output in_valid, wb_ctl, m_ctl, add_result, zero, alu_result, rdata2, dest_reg,
        output dmem_ack, dmem_rdata,
        input  pc_src, branch_target, mem_stall,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  wb_valid, wb_ctlout, wb_rdata, wb_alu, wb_dest, mem_misalign
    );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the instruction when load_i is set, otherwise
// inserts a bubble (valid and control cleared, data fields held).
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        rdata_load_i,
    input  logic [1:0]  ctl_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] alu_i,
    input  logic [4:0]  dest_i,
    output logic        valid_o,
    output logic [1:0]  ctl_o,
    output logic [31:0] rdata_o,
    output logic [31:0] alu_o,
    output logic [4:0]  dest_o
);

    logic        valid_q, valid_d;
    logic [1:0]  ctl_q, ctl_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  dest_q, dest_d;

    always_comb begin
        valid_d = load_i;
        ctl_d   = load_i ? ctl_i : 2'b00;
        alu_d   = load_i ? alu_i : alu_q;
        dest_d  = load_i ? dest_i : dest_q;
        rdata_d = (load_i && rdata_load_i) ? rdata_i : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctl_q   <= 2'b00;
            rdata_q <= 32'h0;
            alu_q   <= 32'h0;
            dest_q  <= 5'h0;
        end else begin
            valid_q <= valid_d;
            ctl_q   <= ctl_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            dest_q  <= dest_d;
        end
    end

    assign valid_o = valid_q;
    assign ctl_o   = ctl_q;
    assign rdata_o = rdata_q;
    assign alu_o   = alu_q;
    assign dest_o  = dest_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS memory-stage controller: data-memory req/ack FSM, pipeline stall, branch resolve
// and MEM/WB load. Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage_ctrl
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mem_stage_ctrl_if.master  bus_io
);

    mem_state_e  state_q, state_d;
    logic        access, misalign;
    logic        mem_stall, launch, ack_done, wb_load, rdata_load;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        misalign_q, misalign_d;
    logic [1:0]  wb_ctl_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = bus_io.in_valid
                    & (bus_io.m_ctl[MEMREAD] | bus_io.m_ctl[MEMWRITE])
                    & (bus_io.alu_result[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign access = bus_io.in_valid & (bus_io.m_ctl[MEMREAD] | bus_io.m_ctl[MEMWRITE])
                  & ~misalign;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (access)          state_d = StReq;
            StReq:  if (bus_io.dmem_ack) state_d = StIdle;
            default:                     state_d = StIdle;
        endcase
    end

    // Output decode; an ack seen in StIdle falls through with no effect
    always_comb begin
        launch   = 1'b0;
        ack_done = 1'b0;
        unique case (state_q)
            StIdle:  launch   = access;
            StReq:   ack_done = bus_io.dmem_ack;
            default: ;
        endcase
        mem_stall  = launch | ((state_q == StReq) & ~bus_io.dmem_ack);
        wb_load    = ~mem_stall & bus_io.in_valid;
        rdata_load = ack_done & ~we_q;
    end

    // MemWrite wins when both MemRead and MemWrite are set
    always_comb begin
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        misalign_d = (state_q == StIdle) & misalign;
        if (launch) begin
            req_d   = 1'b1;
            we_d    = bus_io.m_ctl[MEMWRITE];
            addr_d  = bus_io.alu_result;
            wdata_d = bus_io.rdata2;
        end else if (ack_done) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign wb_ctl_in = misalign ? 2'b00 : bus_io.wb_ctl;

    mem_wb_reg u_mem_wb_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (wb_load),
        .rdata_load_i (rdata_load),
        .ctl_i        (wb_ctl_in),
        .rdata_i      (bus_io.dmem_rdata),
        .alu_i        (bus_io.alu_result),
        .dest_i       (bus_io.dest_reg),
        .valid_o      (bus_io.wb_valid),
        .ctl_o        (bus_io.wb_ctlout),
        .rdata_o      (bus_io.wb_rdata),
        .alu_o        (bus_io.wb_alu),
        .dest_o       (bus_io.wb_dest)
    );

    assign bus_io.pc_src        = bus_io.in_valid & bus_io.m_ctl[BRANCH] & bus_io.zero;
    assign bus_io.branch_target = bus_io.add_result;
    assign bus_io.mem_stall     = mem_stall;
    assign bus_io.dmem_req      = req_q;
    assign bus_io.dmem_we       = we_q;
    assign bus_io.dmem_addr     = addr_q;
    assign bus_io.dmem_wdata    = wdata_q;
    assign bus_io.mem_misalign  = misalign_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: R-type, load/store handshakes, branch, reset
// mid-access and the MEM_ALIGN_CHECK_EN alignment trap when that macro is defined.
module tb_mem_stage_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Outputs sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [4:0] dest);
        bus.in_valid   = 1'b1;
        bus.wb_ctl     = wb;
        bus.m_ctl      = m;
        bus.alu_result = alu;
        bus.rdata2     = wd;
        bus.dest_reg   = dest;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid   = 1'b0;
        bus.wb_ctl     = 2'b00;
        bus.m_ctl      = 3'b000;
        bus.add_result = 32'h0;
        bus.zero       = 1'b0;
        bus.alu_result = 32'h0;
        bus.rdata2     = 32'h0;
        bus.dest_reg   = 5'h0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;

        tick();
        tick();
        check_val("rst_req", bus.dmem_req, 0);
        check_val("rst_wb_valid", bus.wb_valid, 0);
        check_val("rst_wb_ctl", bus.wb_ctlout, 0);
        check_val("rst_addr", bus.dmem_addr, 0);
        check_val("rst_misalign", bus.mem_misalign, 0);
        check_val("rst_stall", bus.mem_stall, 0);
        rst_n = 1'b1;
        tick();

        // R-type
        present(2'b10, 3'b000, 32'h1234, 32'h0, 5'd5);
        #1;
        check_val("rtype_stall", bus.mem_stall, 0);
        tick();
        check_val("rtype_wb_valid", bus.wb_valid, 1);
        check_val("rtype_wb_alu", bus.wb_alu, 32'h1234);
        check_val("rtype_wb_ctl", bus.wb_ctlout, 2'b10);
        check_val("rtype_wb_dest", bus.wb_dest, 5);
        check_val("rtype_req", bus.dmem_req, 0);
        bus.in_valid = 1'b0;
        tick();
        check_val("bubble_valid", bus.wb_valid, 0);
        check_val("bubble_ctl", bus.wb_ctlout, 0);

        // Branch
        present(2'b00, 3'b100, 32'h0, 32'h0, 5'd0);
        bus.zero       = 1'b1;
        bus.add_result = 32'h40;
        #1;
        check_val("br_taken", bus.pc_src, 1);
        check_val("br_target", bus.branch_target, 32'h40);
        check_val("br_stall", bus.mem_stall, 0);
        bus.zero = 1'b0;
        #1;
        check_val("br_not_taken", bus.pc_src, 0);
        bus.zero     = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check_val("br_invalid", bus.pc_src, 0);
        bus.zero = 1'b0;

        // Ack while idle is ignored
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        check_val("idle_ack_req", bus.dmem_req, 0);
        check_val("idle_ack_valid", bus.wb_valid, 0);

        // Load, ack on third request cycle
        present(2'b11, 3'b010, 32'h100, 32'h0, 5'd7);
        #1;
        check_val("ld_c0_stall", bus.mem_stall, 1);
        check_val("ld_c0_req", bus.dmem_req, 0);
        tick();
        check_val("ld_c1_req", bus.dmem_req, 1);
        check_val("ld_c1_addr", bus.dmem_addr, 32'h100);
        check_val("ld_c1_we", bus.dmem_we, 0);
        check_val("ld_c1_stall", bus.mem_stall, 1);
        tick();
        check_val("ld_c2_stall", bus.mem_stall, 1);
        check_val("ld_c2_req", bus.dmem_req, 1);
        check_val("ld_c2_valid", bus.wb_valid, 0);
        tick();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hDEADBEEF;
        #1;
        check_val("ld_ack_stall", bus.mem_stall, 0);
        tick();
        bus.dmem_ack = 1'b0;
        bus.in_valid = 1'b0;
        check_val("ld_wb_valid", bus.wb_valid, 1);
        check_val("ld_wb_rdata", bus.wb_rdata, 32'hDEADBEEF);
        check_val("ld_wb_ctl", bus.wb_ctlout, 2'b11);
        check_val("ld_wb_dest", bus.wb_dest, 7);
        check_val("ld_req_clr", bus.dmem_req, 0);

        // Store, ack on first request cycle
        present(2'b00, 3'b001, 32'h200, 32'hCAFE0001, 5'd0);
        #1;
        check_val("st_c0_stall", bus.mem_stall, 1);
        tick();
        check_val("st_req", bus.dmem_req, 1);
        check_val("st_we", bus.dmem_we, 1);
        check_val("st_wdata", bus.dmem_wdata, 32'hCAFE0001);
        check_val("st_addr", bus.dmem_addr, 32'h200);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h0BAD0BAD;
        #1;
        check_val("st_ack_stall", bus.mem_stall, 0);
        tick();
        bus.dmem_ack = 1'b0;
        bus.in_valid = 1'b0;
        check_val("st_wb_valid", bus.wb_valid, 1);
        check_val("st_wb_ctl", bus.wb_ctlout, 0);
        check_val("st_rdata_hold", bus.wb_rdata, 32'hDEADBEEF);
        check_val("st_req_clr", bus.dmem_req, 0);

        // Back-to-back: load then read+write (treated as write)
        present(2'b11, 3'b010, 32'h300, 32'h0, 5'd3);
        tick();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h11112222;
        #1;
        check_val("b2b_ack_stall", bus.mem_stall, 0);
        tick();
        bus.dmem_ack = 1'b0;
        present(2'b00, 3'b011, 32'h304, 32'h55, 5'd0);
        #1;
        check_val("b2b_wb_rdata", bus.wb_rdata, 32'h11112222);
        check_val("b2b_gap", bus.dmem_req, 0);
        check_val("b2b_stall", bus.mem_stall, 1);
        tick();
        check_val("b2b_req", bus.dmem_req, 1);
        check_val("b2b_addr", bus.dmem_addr, 32'h304);
        check_val("b2b_we", bus.dmem_we, 1);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        bus.in_valid = 1'b0;
        tick();

        // Reset mid-access
        present(2'b11, 3'b010, 32'h500, 32'h0, 5'd9);
        tick();
        check_val("mid_req", bus.dmem_req, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_req", bus.dmem_req, 0);
        check_val("mid_rst_valid", bus.wb_valid, 0);
        check_val("mid_rst_addr", bus.dmem_addr, 0);
        check_val("mid_rst_rdata", bus.wb_rdata, 0);
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        present(2'b11, 3'b010, 32'h400, 32'h0, 5'd4);
        #1;
        check_val("post_rst_stall", bus.mem_stall, 1);
        check_val("post_rst_req0", bus.dmem_req, 0);
        tick();
        check_val("post_rst_req", bus.dmem_req, 1);
        check_val("post_rst_addr", bus.dmem_addr, 32'h400);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h600DF00D;
        tick();
        bus.dmem_ack = 1'b0;
        bus.in_valid = 1'b0;
        check_val("post_rst_rdata", bus.wb_rdata, 32'h600DF00D);
        check_val("post_rst_valid", bus.wb_valid, 1);
        tick();

        // Misaligned load
        present(2'b11, 3'b010, 32'h102, 32'h0, 5'd2);
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        check_val("mis_stall", bus.mem_stall, 0);
        check_val("mis_flag_c0", bus.mem_misalign, 0);
        tick();
        bus.in_valid = 1'b0;
        check_val("mis_flag", bus.mem_misalign, 1);
        check_val("mis_req", bus.dmem_req, 0);
        check_val("mis_wb_valid", bus.wb_valid, 1);
        check_val("mis_wb_ctl", bus.wb_ctlout, 0);
        tick();
        check_val("mis_flag_clr", bus.mem_misalign, 0);
        check_val("mis_req_after", bus.dmem_req, 0);
`else
        check_val("unal_stall", bus.mem_stall, 1);
        tick();
        check_val("unal_req", bus.dmem_req, 1);
        check_val("unal_addr", bus.dmem_addr, 32'h102);
        check_val("unal_flag", bus.mem_misalign, 0);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        bus.in_valid = 1'b0;
        check_val("unal_wb_ctl", bus.wb_ctlout, 2'b11);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller that consumes the EX/MEM pipeline register outputs and drives the data memory over a request/acknowledge handshake. It stalls the pipeline while a load or store is outstanding, resolves the branch decision, and registers results into the MEM/WB stage for write-back. It sits between the EX/MEM register and the write-back mux of the MIPS core.

## Interface
- No parameters; all widths are fixed at 32-bit data/address and a 5-bit register index.
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM holds a live instruction
- wb_ctl  in  2  [1]=RegWrite, [0]=MemtoReg
- m_ctl  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
- add_result  in  32  branch target
- zero  in  1  ALU zero flag
- alu_result  in  32  ALU result / memory address
- rdata2  in  32  store data
- dest_reg  in  5  destination register
- pc_src  out  1  branch taken (combinational)
- branch_target  out  32  = add_result
- mem_stall  out  1  hold IF..EX/MEM this cycle (combinational)
- dmem_req  out  1  access request (registered)
- dmem_we  out  1  1=write
- dmem_addr  out  32  access address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  access complete; read data valid this cycle
- dmem_rdata  in  32  load data
- wb_valid  out  1  MEM/WB holds a live instruction
- wb_ctlout  out  2  registered wb_ctl
- wb_rdata  out  32  registered load data
- wb_alu  out  32  registered alu_result
- wb_dest  out  5  registered dest_reg
- mem_misalign  out  1  misaligned access flag (see Configuration)

## Operation
- Control-signal definitions:
  - access = in_valid & (m_ctl[1] | m_ctl[0]).
  - If MemRead and MemWrite are both set, the access is treated as a write.
  - pc_src = in_valid & m_ctl[2] & zero. It is independent of the FSM.
- FSM states: IDLE, REQ.
  - IDLE → REQ: on access.
  - REQ → IDLE: on dmem_ack.
  - REQ with no dmem_ack: stay in REQ.
- Request signals:
  - On IDLE→REQ, latch dmem_addr=alu_result, dmem_wdata=rdata2, dmem_we=m_ctl[0], and set dmem_req=1.
  - All four hold stable until the ack cycle.
  - dmem_req clears at the edge that ends the ack cycle.
- mem_stall = (IDLE & access) | (REQ & ~dmem_ack).
- MEM/WB load each cycle:
  - When ~mem_stall & in_valid: wb_valid=1 and the inputs are captured. wb_rdata takes dmem_rdata on a load-ack cycle; otherwise it holds its previous value.
  - Otherwise a bubble is loaded: wb_valid=0, wb_ctlout=00.
- Stores complete with wb_ctlout as supplied; the decoder guarantees RegWrite=0 for stores.
- A dmem_ack seen in IDLE is ignored.

## Timing
- Non-memory instruction: one cycle through the stage. mem_stall stays 0.
- Load/store:
  - cycle 0: presented, mem_stall=1.
  - cycle 1: dmem_req=1.
  - ack cycle N≥1: mem_stall=0 and EX/MEM advances.
  - MEM/WB valid at N+1.
  - Minimum 2 cycles; each extra wait cycle adds one.
- Back-to-back accesses: a new access is presented in the cycle after the ack and returns IDLE→REQ. dmem_req has a minimum one-cycle low gap.
- Reset (any time, including mid-access): state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_ctlout=0, wb_rdata=0, wb_alu=0, wb_dest=0, mem_misalign=0. An outstanding access is abandoned; the memory must tolerate a dropped dmem_req.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - An access with alu_result[1:0]≠00 issues no request and does not stall.
  - mem_misalign=1 for exactly the cycle after presentation (registered).
  - MEM/WB loads the instruction with wb_ctlout forced to 00.
- MEM_ALIGN_CHECK_EN undefined:
  - mem_misalign is tied 0.
  - Addresses pass unchecked to dmem_addr.

## Structure
- Shared package mips_pkg holds:
  - bit-index constants for m_ctl (BRANCH=2, MEMREAD=1, MEMWRITE=0) and wb_ctl (REGWRITE=1, MEMTOREG=0);
  - the memory-stage state encoding (IDLE=0, REQ=1).
- One sub-module, mem_wb_reg, holds the MEM/WB flops with load/bubble control. The FSM, handshake and branch logic live in mem_stage_ctrl.

## Test plan
- R-type, in_valid=1, wb_ctl=10, m_ctl=000, alu_result=0x1234 → no stall; next cycle wb_valid=1, wb_alu=0x1234, dmem_req never rises.
- Load, alu_result=0x100, memory acks 3 cycles after the request with rdata=0xDEADBEEF → mem_stall high for 3 cycles, dmem_addr=0x100, dmem_we=0; wb_rdata=0xDEADBEEF the cycle after ack.
- Store, alu_result=0x200, rdata2=0xCAFE0001, ack on the first request cycle → dmem_we=1, dmem_wdata=0xCAFE0001; stall lasts exactly 1 cycle.
- Branch, m_ctl=100, zero=1, add_result=0x40 → pc_src=1 and branch_target=0x40 in the same cycle; with zero=0, pc_src=0.
- rst_n pulled low while in REQ without ack → dmem_req=0 and wb_valid=0 immediately; after release, state is IDLE and a new load proceeds normally.
- With MEM_ALIGN_CHECK_EN, load at 0x102 → no dmem_req, no stall, mem_misalign pulses 1 cycle, wb_ctlout=00.
